// File: rtl/chunked_seq_adder_pkg.sv
// ============================================================================
// Module      : chunked_seq_adder_pkg
// Description : Shared state encoding and sizing helper for chunked_seq_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chunked_seq_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Chunk index width: clog2 of the chunk count, never narrower than one bit.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunked_seq_adder_if.sv
// ============================================================================
// Module      : chunked_seq_adder_if
// Description : Operand/result valid-ready bundle for chunked_seq_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chunked_seq_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/chunked_seq_adder_chunk_adder.sv
// ============================================================================
// Module      : chunk_adder
// Description : CHUNK-bit ripple-carry adder exposing the carry into its MSB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  wire logic [CHUNK-1:0] i_a,
  input  wire logic [CHUNK-1:0] i_b,
  input  wire logic             i_cin,
  output logic      [CHUNK-1:0] o_sum,
  output logic                  o_cout,
  output logic                  o_c_msb
);

  logic w_c;

  // Carry threaded bit by bit through the loop keeps this a true ripple chain.
  always_comb begin
    w_c     = i_cin;
    o_c_msb = 1'b0;
    o_sum   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) o_c_msb = w_c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

`default_nettype wire

// File: rtl/chunked_seq_adder.sv
// ============================================================================
// Module      : chunked_seq_adder
// Description : Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input wire logic         clk,
  input wire logic         rst_n,
  chunked_seq_adder_if.slave bus
);

  localparam int c_nch  = WIDTH / CHUNK;
  localparam int c_idxw = idx_width(WIDTH, CHUNK);
  localparam logic [c_idxw-1:0] c_last = c_idxw'(c_nch - 1);

  localparam logic [1:0] c_idle = S_IDLE;
  localparam logic [1:0] c_run  = S_RUN;
  localparam logic [1:0] c_done = S_DONE;

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [c_idxw-1:0] r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [CHUNK-1:0]  w_a_chk;
  logic [CHUNK-1:0]  w_b_chk;
  logic [CHUNK-1:0]  w_chk_sum;
  logic              w_chk_cout;
  logic              w_chk_cmsb;

  always_comb begin
    w_a_chk = '0;
    w_b_chk = '0;
    for (int i = 0; i < c_nch; i++) begin
      if (r_idx == c_idxw'(i)) begin
        w_a_chk = r_a[i*CHUNK +: CHUNK];
        w_b_chk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a     (w_a_chk),
    .i_b     (w_b_chk),
    .i_cin   (r_carry),
    .o_sum   (w_chk_sum),
    .o_cout  (w_chk_cout),
    .o_c_msb (w_chk_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.in_valid) begin
            // Subtract is A + ~B + 1, so the operand is inverted on capture.
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_idx   <= '0;
            r_state <= c_run;
          end
        end
        c_run: begin
          for (int i = 0; i < c_nch; i++) begin
            if (r_idx == c_idxw'(i)) r_sum[i*CHUNK +: CHUNK] <= w_chk_sum;
          end
          r_carry <= w_chk_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == c_last) begin
            r_cout  <= w_chk_cout;
            r_ovf   <= w_chk_cmsb ^ w_chk_cout;
            r_state <= c_done;
          end
        end
        c_done: begin
          if (bus.out_ready) r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == c_idle);
  assign bus.out_valid = (r_state == c_done);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire
